// File: rtl/hazard_pkg.sv
// +-----------------------------------------------------------------------+
// | hazard_pkg: shared types and constants for the pipeline hazard unit   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

   localparam int HZ_ADDR_W = 4;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_e;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic                 valid;
      logic [HZ_ADDR_W-1:0] waddr;
      logic                 wen;
      logic                 is_load;
      logic [HZ_ADDR_W-1:0] rs;
      logic [HZ_ADDR_W-1:0] rt;
      logic                 rs_used;
      logic                 rt_used;
   } slot_t;

   // A load still in MEM has no data yet, so only WB may supply it.
   function automatic logic [1:0] fwd_sel(input logic used,
                                          input logic [HZ_ADDR_W-1:0] addr,
                                          input slot_t mem,
                                          input slot_t wb);
      logic [1:0] sel;
      sel = FWD_REG;
      if (used && (addr != '0)) begin
         if (mem.valid && mem.wen && !mem.is_load && (mem.waddr == addr))
            sel = FWD_MEM;
         else if (wb.valid && wb.wen && (wb.waddr == addr))
            sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// +-----------------------------------------------------------------------+
// | hazard_scoreboard: EXE/MEM/WB shadow slots, load-use and forwarding   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module hazard_scoreboard
   import hazard_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       advance_i,
   input  logic       load_i,
   input  slot_t      id_slot_i,
   output logic       lu_hazard_o,
   output logic [1:0] fwd_a_o,
   output logic [1:0] fwd_b_o
);

   slot_t exe_q;
   slot_t mem_q;
   slot_t wb_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         exe_q <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (advance_i) begin
         wb_q  <= mem_q;
         mem_q <= exe_q;
         exe_q <= load_i ? id_slot_i : '0;
      end
   end

   assign lu_hazard_o = exe_q.valid & exe_q.is_load & exe_q.wen &
                        (exe_q.waddr != '0) & id_slot_i.valid &
                        ((id_slot_i.rs_used & (id_slot_i.rs == exe_q.waddr)) |
                         (id_slot_i.rt_used & (id_slot_i.rt == exe_q.waddr)));

   assign fwd_a_o = fwd_sel(exe_q.rs_used, exe_q.rs, mem_q, wb_q);
   assign fwd_b_o = fwd_sel(exe_q.rt_used, exe_q.rt, mem_q, wb_q);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// +-----------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stall/flush/freeze sequencing for 5-stage pipe  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int ADDR_W       = 4,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
)(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              id_valid_i,
   input  logic [ADDR_W-1:0] id_rs_i,
   input  logic [ADDR_W-1:0] id_rt_i,
   input  logic              id_rs_used_i,
   input  logic              id_rt_used_i,
   input  logic [ADDR_W-1:0] id_waddr_i,
   input  logic              id_wen_i,
   input  logic              id_is_load_i,
   input  logic              branch_taken_exe_i,
   input  logic              dmem_req_i,
   input  logic              dmem_ready_i,
   output logic              pc_en_o,
   output logic              if_id_en_o,
   output logic              id_exe_en_o,
   output logic              exe_mem_en_o,
   output logic              mem_wb_en_o,
   output logic              flush_if_id_o,
   output logic              flush_id_exe_o,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   state_e           state_q, state_d;
   state_e           ret_q, ret_d;
   logic [1:0]       fcnt_q, fcnt_d;
   logic [CNT_W-1:0] stall_q;

   state_e eff_state;
   logic   frozen;
   logic   flushing;
   logic   lu_hazard;
   slot_t  id_slot;

   assign id_slot = '{valid:   id_valid_i,
                      waddr:   id_waddr_i,
                      wen:     id_wen_i,
                      is_load: id_is_load_i,
                      rs:      id_rs_i,
                      rt:      id_rt_i,
                      rs_used: id_rs_used_i,
                      rt_used: id_rt_used_i};

   // The cycle dmem_ready rises is already unfrozen and behaves as the saved state.
   assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
   assign frozen    = dmem_req_i & ~dmem_ready_i;

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      fcnt_d   = fcnt_q;
      flushing = 1'b0;
      if (frozen) begin
         if (state_q != ST_MEM_WAIT)
            ret_d = state_q;
         state_d = ST_MEM_WAIT;
      end else if (branch_taken_exe_i) begin
         flushing = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = 2'(FLUSH_CYCLES - 1);
         end else begin
            state_d = ST_RUN;
            fcnt_d  = 2'd0;
         end
      end else if (eff_state == ST_FLUSH) begin
         flushing = 1'b1;
         if (fcnt_q <= 2'd1) begin
            state_d = ST_RUN;
            fcnt_d  = 2'd0;
         end else begin
            state_d = ST_FLUSH;
            fcnt_d  = fcnt_q - 2'd1;
         end
      end else begin
         state_d = ST_RUN;
      end
   end

   always_comb begin
      pc_en_o        = 1'b1;
      if_id_en_o     = 1'b1;
      id_exe_en_o    = 1'b1;
      exe_mem_en_o   = 1'b1;
      mem_wb_en_o    = 1'b1;
      flush_if_id_o  = 1'b0;
      flush_id_exe_o = 1'b0;
      if (!rst_ni) begin
         pc_en_o        = 1'b0;
         if_id_en_o     = 1'b0;
         id_exe_en_o    = 1'b0;
         exe_mem_en_o   = 1'b0;
         mem_wb_en_o    = 1'b0;
         flush_if_id_o  = 1'b1;
         flush_id_exe_o = 1'b1;
      end else if (frozen) begin
         pc_en_o      = 1'b0;
         if_id_en_o   = 1'b0;
         id_exe_en_o  = 1'b0;
         exe_mem_en_o = 1'b0;
         mem_wb_en_o  = 1'b0;
      end else if (flushing) begin
         flush_if_id_o  = 1'b1;
         flush_id_exe_o = 1'b1;
      end else if (lu_hazard) begin
         pc_en_o        = 1'b0;
         if_id_en_o     = 1'b0;
         flush_id_exe_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_RUN;
         ret_q   <= ST_RUN;
         fcnt_q  <= 2'd0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         fcnt_q  <= fcnt_d;
         if (!pc_en_o && (stall_q != '1))
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign stall_cnt_o = stall_q;

   hazard_scoreboard u_scoreboard (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .advance_i   (~frozen),
      .load_i      (id_exe_en_o & ~flush_id_exe_o),
      .id_slot_i   (id_slot),
      .lu_hazard_o (lu_hazard),
      .fwd_a_o     (fwd_a_o),
      .fwd_b_o     (fwd_b_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl: vector table + expected-result queue bench   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0;
   logic [3:0] id_rs = '0, id_rt = '0, id_waddr = '0;
   logic       id_rs_used = 1'b0, id_rt_used = 1'b0, id_wen = 1'b0, id_is_load = 1'b0;
   logic       br = 1'b0, dreq = 1'b0, drdy = 1'b0;
   logic       pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
   logic       fl_if_id, fl_id_exe;
   logic [1:0] fwd_a, fwd_b;
   logic [3:0] stall_cnt;

   logic [4:0] en_w;
   logic [1:0] fl_w;
   assign en_w = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en};
   assign fl_w = {fl_if_id, fl_id_exe};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.ADDR_W(4), .FLUSH_CYCLES(1), .CNT_W(4)) dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .id_valid_i         (id_valid),
      .id_rs_i            (id_rs),
      .id_rt_i            (id_rt),
      .id_rs_used_i       (id_rs_used),
      .id_rt_used_i       (id_rt_used),
      .id_waddr_i         (id_waddr),
      .id_wen_i           (id_wen),
      .id_is_load_i       (id_is_load),
      .branch_taken_exe_i (br),
      .dmem_req_i         (dreq),
      .dmem_ready_i       (drdy),
      .pc_en_o            (pc_en),
      .if_id_en_o         (if_id_en),
      .id_exe_en_o        (id_exe_en),
      .exe_mem_en_o       (exe_mem_en),
      .mem_wb_en_o        (mem_wb_en),
      .flush_if_id_o      (fl_if_id),
      .flush_id_exe_o     (fl_id_exe),
      .fwd_a_o            (fwd_a),
      .fwd_b_o            (fwd_b),
      .stall_cnt_o        (stall_cnt)
   );

   typedef struct {
      logic [3:0] rs, rt, wd;
      logic       rsu, rtu, wen, ld;
      logic [2:0] ctl;   // {branch_taken, dmem_req, dmem_ready}
      logic [4:0] en;    // {pc, if_id, id_exe, exe_mem, mem_wb}
      logic [1:0] fl;    // {flush_if_id, flush_id_exe}
      logic [1:0] fa, fb;
      logic [3:0] sc;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   function automatic vec_t V(input logic [3:0] rs, rt, input logic rsu, rtu,
                              input logic [3:0] wd, input logic wen, ld,
                              input logic [2:0] ctl, input logic [4:0] en,
                              input logic [1:0] fl, fa, fb, input logic [3:0] sc);
      vec_t v;
      v.rs = rs; v.rt = rt; v.rsu = rsu; v.rtu = rtu; v.wd = wd; v.wen = wen; v.ld = ld;
      v.ctl = ctl; v.en = en; v.fl = fl; v.fa = fa; v.fb = fb; v.sc = sc;
      return v;
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic drive(input vec_t v);
      id_rs = v.rs; id_rt = v.rt; id_rs_used = v.rsu; id_rt_used = v.rtu;
      id_waddr = v.wd; id_wen = v.wen; id_is_load = v.ld;
      id_valid = v.rsu | v.rtu | v.wen;
      {br, dreq, drdy} = v.ctl;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t e;
      vec_t nop;
      nop = V(0,0,0,0,0,0,0, 3'b000, 5'h00, 2'b00, 0, 0, 0);

      // lw r3 ; add r4,r3,r5 : one-cycle load-use stall, then WB forward
      vecs.push_back(V(1,0,1,0, 3,1,1, 3'b000, 5'b11111, 2'b00, 0,0, 0));
      vecs.push_back(V(3,5,1,1, 4,1,0, 3'b000, 5'b00111, 2'b01, 0,0, 0));
      vecs.push_back(V(3,5,1,1, 4,1,0, 3'b000, 5'b11111, 2'b00, 0,0, 1));
      vecs.push_back(V(0,0,0,0, 0,0,0, 3'b000, 5'b11111, 2'b00, 2,0, 1));
      // add r2 ; sub r6,r2,r2 (MEM fwd) ; indep ; or r10,r6,r6 (WB fwd)
      vecs.push_back(V(1,1,1,1, 2,1,0, 3'b000, 5'b11111, 2'b00, 0,0, 1));
      vecs.push_back(V(2,2,1,1, 6,1,0, 3'b000, 5'b11111, 2'b00, 0,0, 1));
      vecs.push_back(V(8,9,1,1, 7,1,0, 3'b000, 5'b11111, 2'b00, 1,1, 1));
      vecs.push_back(V(6,6,1,1,10,1,0, 3'b000, 5'b11111, 2'b00, 0,0, 1));
      vecs.push_back(V(0,0,0,0, 0,0,0, 3'b000, 5'b11111, 2'b00, 2,2, 1));
      // lw r5 ; consumer with branch taken in the same cycle
      vecs.push_back(V(1,0,1,0, 5,1,1, 3'b000, 5'b11111, 2'b00, 0,0, 1));
      vecs.push_back(V(5,0,1,1,11,1,0, 3'b100, 5'b11111, 2'b11, 0,0, 1));
      vecs.push_back(V(0,0,0,0, 0,0,0, 3'b000, 5'b11111, 2'b00, 0,0, 1));
      // add r12 ; sub r13,r12,r5 then a 3-cycle memory wait (branch ignored while frozen)
      vecs.push_back(V(1,1,1,1,12,1,0, 3'b000, 5'b11111, 2'b00, 0,0, 1));
      vecs.push_back(V(12,5,1,1,13,1,0,3'b000, 5'b11111, 2'b00, 0,0, 1));
      vecs.push_back(V(0,0,0,0, 0,0,0, 3'b010, 5'b00000, 2'b00, 1,0, 1));
      vecs.push_back(V(0,0,0,0, 0,0,0, 3'b110, 5'b00000, 2'b00, 1,0, 2));
      vecs.push_back(V(0,0,0,0, 0,0,0, 3'b110, 5'b00000, 2'b00, 1,0, 3));
      vecs.push_back(V(0,0,0,0, 0,0,0, 3'b011, 5'b11111, 2'b00, 1,0, 4));
      vecs.push_back(V(0,0,0,0, 0,0,0, 3'b000, 5'b11111, 2'b00, 0,0, 4));
      // lw r0 ; readers of r0 : never a stall, never forwarded
      vecs.push_back(V(1,0,1,0, 0,1,1, 3'b000, 5'b11111, 2'b00, 0,0, 4));
      vecs.push_back(V(0,0,1,1,14,1,0, 3'b000, 5'b11111, 2'b00, 0,0, 4));
      vecs.push_back(V(0,0,1,1,15,1,0, 3'b000, 5'b11111, 2'b00, 0,0, 4));
      vecs.push_back(V(0,0,0,0, 0,0,0, 3'b000, 5'b11111, 2'b00, 0,0, 4));
      // two writers of r2 back-to-back : the younger one in MEM wins over WB
      vecs.push_back(V(1,1,1,1, 2,1,0, 3'b000, 5'b11111, 2'b00, 0,0, 4));
      vecs.push_back(V(1,1,1,1, 2,1,0, 3'b000, 5'b11111, 2'b00, 0,0, 4));
      vecs.push_back(V(2,2,1,1, 3,1,0, 3'b000, 5'b11111, 2'b00, 0,0, 4));
      vecs.push_back(V(0,0,0,0, 0,0,0, 3'b000, 5'b11111, 2'b00, 1,1, 4));

      drive(nop);
      repeat (2) @(posedge clk);
      #1;
      check("reset.en", 16'(en_w), 16'h00);
      check("reset.fl", 16'(fl_w), 16'h3);
      check("reset.fwd", 16'({fwd_a, fwd_b}), 16'h0);
      check("reset.sc", 16'(stall_cnt), 16'h0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         exp_q.push_back(vecs[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("v%0d.en", i), 16'(en_w), 16'(e.en));
         check($sformatf("v%0d.fl", i), 16'(fl_w), 16'(e.fl));
         check($sformatf("v%0d.fwd_a", i), 16'(fwd_a), 16'(e.fa));
         check($sformatf("v%0d.fwd_b", i), 16'(fwd_b), 16'(e.fb));
         check($sformatf("v%0d.stall_cnt", i), 16'(stall_cnt), 16'(e.sc));
         @(posedge clk);
         #1;
      end

      // Reset asserted between edges during a memory wait
      drive(nop);
      dreq = 1'b1; drdy = 1'b0;
      #2;
      check("prerst.en", 16'(en_w), 16'h00);
      rst_n = 1'b0;
      #1;
      check("midrst.en", 16'(en_w), 16'h00);
      check("midrst.fl", 16'(fl_w), 16'h3);
      check("midrst.fwd", 16'({fwd_a, fwd_b}), 16'h0);
      check("midrst.sc", 16'(stall_cnt), 16'h0);
      @(posedge clk);
      #1;
      check("inrst.sc", 16'(stall_cnt), 16'h0);
      rst_n = 1'b1;
      dreq = 1'b0;
      #1;
      check("postrst.en", 16'(en_w), 16'h1f);
      check("postrst.fl", 16'(fl_w), 16'h0);
      @(posedge clk);
      #1;
      check("postrst.sc", 16'(stall_cnt), 16'h0);

      // Long freeze saturates the 4-bit stall counter
      dreq = 1'b1; drdy = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("sat.sc", 16'(stall_cnt), 16'hf);
      check("sat.en", 16'(en_w), 16'h00);
      dreq = 1'b0;
      #1;
      check("unfreeze.en", 16'(en_w), 16'h1f);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
